// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave block.
//   DataWDefault      - default frame length in bits
//   SyncStagesDefault - default flop count per input synchronizer
//   spi_state_e       - FSM state encoding (idle / shifting a frame)
//   cnt_width()       - width of a counter that indexes a frame bit
package spi_pkg;

    localparam int unsigned DataWDefault      = 8;
    localparam int unsigned SyncStagesDefault = 2;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } spi_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bus bundle between an SPI slave and its surroundings.
//   sclk, cs_n, mosi         - serial side, driven by the SPI master
//   miso, miso_oe            - serial return data and its drive enable
//   tx_data/tx_valid/tx_ready - parallel transmit holding-register load
//   rx_data/rx_valid          - last received frame and its one-clk strobe
//   busy, tx_underrun         - frame-in-progress and empty-fetch status
// Modport slave is the device side; modport master is the environment side.
interface spi_slave_if #(
    parameter int unsigned DATA_W = spi_pkg::DataWDefault
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              tx_underrun;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
//   clk     - destination clock
//   reset   - asynchronous, active-high; loads RESET_VAL into every stage
//   d_i     - asynchronous input
//   q_o     - synchronized output (last stage)
// STAGES below 2 is raised to 2.
module spi_sync #(
    parameter int unsigned STAGES    = spi_pkg::SyncStagesDefault,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    localparam int unsigned Stages = (STAGES < 2) ? 2 : STAGES;

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {Stages{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampling sclk/cs_n/mosi in the clk domain.
//   clk    - system clock (must be at least 4x sclk)
//   reset  - asynchronous, active-high
//   bus    - spi_slave_if.slave: serial pins, tx holding-register load,
//            rx frame output, busy and tx_underrun status
// A frame starts on cs_n falling or, with cs_n held low, at the sclk falling
// edge after the last bit of the previous frame. At each frame start the
// transmit shift register fetches the holding register (or zeros + underrun).
module spi_slave #(
    parameter int unsigned DATA_W      = spi_pkg::DataWDefault,
    parameter int unsigned SYNC_STAGES = spi_pkg::SyncStagesDefault
) (
    input  logic            clk,
    input  logic            reset,
    spi_slave_if.slave      bus
);
    import spi_pkg::*;

    localparam int unsigned     CntW    = cnt_width(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    // Synchronized serial inputs and their previous samples
    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_prev_q, cs_n_prev_q;
    logic sclk_rise, sclk_fall, cs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.sclk),
        .q_o   (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.cs_n),
        .q_o   (cs_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.mosi),
        .q_o   (mosi_s)
    );

    spi_state_e        state_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [DATA_W-1:0] tx_shift_q;
    logic [DATA_W-1:0] rx_shift_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              underrun_q;
    logic              reload_q;     // frame just completed, fetch at next sclk fall
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;

    logic              tx_load;
    logic              fetch;
    logic [DATA_W-1:0] fetch_word;
    logic [DATA_W-1:0] rx_next;

    always_comb begin
        sclk_rise  = sclk_s & ~sclk_prev_q;
        sclk_fall  = ~sclk_s & sclk_prev_q;
        cs_fall    = ~cs_n_s & cs_n_prev_q;
        tx_load    = bus.tx_valid & ~hold_full_q;
        fetch_word = hold_full_q ? hold_q : '0;
        rx_next    = {rx_shift_q[DATA_W-2:0], mosi_s};
        fetch      = ((state_q == StIdle) && cs_fall) ||
                     ((state_q == StShift) && !cs_n_s && sclk_fall && reload_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            reload_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;

            // A fetch empties the holding register. A load in the same cycle
            // can only happen when it was already empty, so the fetch reports
            // underrun and the new word is kept for the following frame.
            if (fetch) begin
                hold_full_q <= 1'b0;
            end
            if (tx_load) begin
                hold_q      <= bus.tx_data;
                hold_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q    <= StShift;
                        tx_shift_q <= fetch_word;
                        underrun_q <= ~hold_full_q;
                        bit_cnt_q  <= '0;
                        reload_q   <= 1'b0;
                    end
                end
                StShift: begin
                    if (cs_n_s) begin
                        // Deselect aborts any partial frame without a strobe
                        state_q    <= StIdle;
                        bit_cnt_q  <= '0;
                        tx_shift_q <= '0;
                        rx_shift_q <= '0;
                        reload_q   <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift_q <= rx_next;
                            if (bit_cnt_q == LastBit) begin
                                rx_data_q  <= rx_next;
                                rx_valid_q <= 1'b1;
                                bit_cnt_q  <= '0;
                                reload_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (reload_q) begin
                                tx_shift_q <= fetch_word;
                                underrun_q <= ~hold_full_q;
                                reload_q   <= 1'b0;
                            end else begin
                                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.miso        = (state_q == StShift) & tx_shift_q[DATA_W-1];
    assign bus.miso_oe     = (state_q == StShift);
    assign bus.busy        = (state_q == StShift);
    assign bus.tx_ready    = ~hold_full_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave (DATA_W=8, SYNC_STAGES=2).
// The bench plays SPI master in mode 0 with sclk at 1/10 of clk.
module tb_spi_slave;

    localparam int HALF = 5;   // clk cycles per sclk half period

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_if #(.DATA_W(8)) bus ();

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Event monitor, sampled on the inactive clock edge
    int         rx_cnt = 0;
    int         ur_cnt = 0;
    int         dbl_cnt = 0;
    bit         rx_valid_prev = 1'b0;
    logic [7:0] rx_log [16];

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = bus.rx_data;
            rx_cnt++;
        end
        if (bus.tx_underrun === 1'b1) ur_cnt++;
        if (bus.rx_valid === 1'b1 && rx_valid_prev) dbl_cnt++;
        rx_valid_prev = (bus.rx_valid === 1'b1);
    end

    task automatic push_tx(input logic [7:0] v);
        @(negedge clk);
        bus.tx_data  = v;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_assert();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_release();
        repeat (HALF) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Shift nbits out MSB first; optionally load the holding register after bit 3
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit mid_load,
                        input logic [7:0] mid_val, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            got = {got[6:0], bus.miso};
            bus.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.sclk = 1'b0;
            if (mid_load && i == 3) push_tx(mid_val);
        end
    endtask

    task automatic test_reset();
        total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", bus.miso); end
        total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", bus.miso_oe); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", bus.tx_underrun); end
    endtask

    task automatic test_single_frame();
        logic [7:0] got;
        int rx0;
        push_tx(8'hA5);
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL single_ready_full got=%b exp=0", bus.tx_ready); end
        rx0 = rx_cnt;
        cs_assert();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
        total++; if (bus.miso_oe !== 1'b1) begin bad++; $display("FAIL single_oe got=%b exp=1", bus.miso_oe); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL single_ready_after_start got=%b exp=1", bus.tx_ready); end
        xfer(8'h3C, 8, 1'b0, 8'h00, got);
        cs_release();
        total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("FAIL single_rx_pulses got=%0d exp=1", rx_cnt - rx0); end
        total++; if (bus.rx_data !== 8'h3C) begin bad++; $display("FAIL single_rx_data got=%h exp=3c", bus.rx_data); end
        total++; if (got !== 8'hA5) begin bad++; $display("FAIL single_miso got=%h exp=a5", got); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", bus.busy); end
        total++; if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
            bad++; $display("FAIL single_oe_end got oe=%b miso=%b exp=0/0", bus.miso_oe, bus.miso);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got0, got1;
        int rx0;
        push_tx(8'h81);
        rx0 = rx_cnt;
        cs_assert();
        xfer(8'h11, 8, 1'b1, 8'h7E, got0);
        xfer(8'h22, 8, 1'b0, 8'h00, got1);
        cs_release();
        total++; if (rx_cnt - rx0 !== 2) begin bad++; $display("FAIL b2b_rx_pulses got=%0d exp=2", rx_cnt - rx0); end
        total++; if (rx_log[rx0] !== 8'h11) begin bad++; $display("FAIL b2b_rx0 got=%h exp=11", rx_log[rx0]); end
        total++; if (rx_log[rx0+1] !== 8'h22) begin bad++; $display("FAIL b2b_rx1 got=%h exp=22", rx_log[rx0+1]); end
        total++; if (got0 !== 8'h81) begin bad++; $display("FAIL b2b_miso0 got=%h exp=81", got0); end
        total++; if (got1 !== 8'h7E) begin bad++; $display("FAIL b2b_miso1 got=%h exp=7e", got1); end
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        int ur0;
        ur0 = ur_cnt;
        cs_assert();
        total++; if (ur_cnt - ur0 !== 1) begin bad++; $display("FAIL underrun_pulse got=%0d exp=1", ur_cnt - ur0); end
        xfer(8'hFF, 8, 1'b0, 8'h00, got);
        cs_release();
        total++; if (got !== 8'h00) begin bad++; $display("FAIL underrun_miso got=%h exp=00", got); end
        total++; if (bus.rx_data !== 8'hFF) begin bad++; $display("FAIL underrun_rx_data got=%h exp=ff", bus.rx_data); end
    endtask

    task automatic test_abort();
        logic [7:0] got;
        int rx0;
        rx0 = rx_cnt;
        cs_assert();
        xfer(8'hA8, 5, 1'b0, 8'h00, got);
        cs_release();
        total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL abort_no_rx got=%0d exp=0", rx_cnt - rx0); end
        total++; if (bus.rx_data !== 8'hFF) begin bad++; $display("FAIL abort_rx_kept got=%h exp=ff", bus.rx_data); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        push_tx(8'h5A);
        cs_assert();
        xfer(8'h55, 8, 1'b0, 8'h00, got);
        cs_release();
        total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("FAIL abort_next_pulses got=%0d exp=1", rx_cnt - rx0); end
        total++; if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL abort_next_rx got=%h exp=55", bus.rx_data); end
        total++; if (got !== 8'h5A) begin bad++; $display("FAIL abort_next_miso got=%h exp=5a", got); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int rx0;
        push_tx(8'h66);
        rx0 = rx_cnt;
        cs_assert();
        xfer(8'hE0, 3, 1'b0, 8'h00, got);
        @(negedge clk);
        reset = 1'b1;
        #1;
        test_reset();
        bus.cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL rstmid_no_rx got=%0d exp=0", rx_cnt - rx0); end
        push_tx(8'h3C);
        cs_assert();
        xfer(8'hC3, 8, 1'b0, 8'h00, got);
        cs_release();
        total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("FAIL rstmid_pulses got=%0d exp=1", rx_cnt - rx0); end
        total++; if (bus.rx_data !== 8'hC3) begin bad++; $display("FAIL rstmid_rx got=%h exp=c3", bus.rx_data); end
        total++; if (got !== 8'h3C) begin bad++; $display("FAIL rstmid_miso got=%h exp=3c", got); end
    endtask

    task automatic test_idle_sclk();
        logic [7:0] got;
        int rx0;
        int oe_seen;
        push_tx(8'h99);
        rx0 = rx_cnt;
        oe_seen = 0;
        bus.mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.sclk = ~bus.sclk;
            repeat (HALF) @(negedge clk);
            if (bus.miso_oe !== 1'b0) oe_seen++;
        end
        total++; if (oe_seen !== 0) begin bad++; $display("FAIL idle_oe got=%0d exp=0", oe_seen); end
        total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL idle_no_rx got=%0d exp=0", rx_cnt - rx0); end
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b exp=0", bus.tx_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
        cs_assert();
        xfer(8'h00, 8, 1'b0, 8'h00, got);
        cs_release();
        total++; if (got !== 8'h99) begin bad++; $display("FAIL idle_hold_data got=%h exp=99", got); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL idle_rx got=%h exp=00", bus.rx_data); end
    endtask

    initial begin
        reset        = 1'b1;
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_reset_mid();
        test_idle_sclk();
        total++; if (dbl_cnt !== 0) begin bad++; $display("FAIL rx_valid_width got=%0d long pulses exp=0", dbl_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
